sram_access_scheduler: RTL and testbench
========================================

// Module: sram_access_scheduler
// PURPOSE
//  Owns the single foreground SRAM port and schedules every access to it: pipeline pixel reads, ADC FIFO writes and SPI image writes.
//  Runs the freeze-frame state machine, aligning freeze/unfreeze to frame boundaries so no frame is torn.
//  Reads always win. Writes use idle cycles. A 3-cycle read pipeline returns data or a blank pixel.
//  Sits between the FG pipeline/ADC FIFO/SPI receiver and sram_interface.
// PARAMETERS
//  X_RES      800  FG width; x >= X_RES is out of bounds
//  Y_RES      600  FG height; y >= Y_RES is out of bounds
//  PRECISION  11   signed coordinate width is PRECISION+1
//  RD_LAT     3    rd_req -> rd_valid latency; fixed by sram_interface, do not change
// PORTS
//  clk             in   1       system clock
//  rst             in   1       async, active-high reset
//  freeze_req      in   1       level: 1 = user wants freeze-frame
//  frame_start     in   1       1-cycle pulse at start of each ADC frame
//  frozen          out  1       1 in FROZEN and THAW
//  rd_req          in   1       pipeline read request
//  rd_x, rd_y      in   P+1     signed read coordinates
//  rd_data         out  16      read pixel (0 if out of bounds)
//  rd_valid        out  1       rd_data valid; exactly RD_LAT cycles after rd_req
//  adc_data        in   38      {x[37:27], y[26:16], pixel[15:0]} from FIFO
//  adc_ready       in   1       FIFO not empty
//  adc_read        out  1       FIFO pop; combinational
//  spi_ready       in   1       SPI pixel pending
//  spi_x, spi_y    in   P+1     signed SPI coordinates
//  spi_pixel       in   16      SPI pixel
//  spi_ack         out  1       1-cycle pulse when the SPI write is committed
//  adc_drop_cnt    out  16      saturating count of popped but unwritten ADC pixels
//  sram_we         out  1       to sram_interface, registered
//  sram_addr       out  20      {x[9:0], y[9:0]}, registered
//  sram_data_in    out  17      {1'b0, pixel}, registered
//  sram_data_out   in   17      from sram_interface
// BEHAVIOUR
//  Reset: state=LIVE. All outputs 0. Read/SPI shift registers cleared. In-flight reads are discarded, so no rd_valid follows reset.
//  Freeze FSM (all transitions on registered state):
//   LIVE -> DRAIN on freeze_req=1. ADC writes enabled.
//   DRAIN: ADC writes still enabled, finishing the current frame.
//    -> FROZEN on frame_start.
//    -> LIVE if freeze_req=0.
//   FROZEN: ADC writes off, SPI writes on. -> THAW on freeze_req=0.
//   THAW: no writes.
//    -> LIVE on frame_start.
//    -> FROZEN if freeze_req=1 again.
//    freeze_req and frame_start together in THAW -> FROZEN (freeze_req wins).
//  Slot priority each cycle: rd_req > ADC write (LIVE/DRAIN) > SPI write (FROZEN) > idle (sram_we=0).
//  Read:
//   - In bounds when 0 <= x < X_RES and 0 <= y < Y_RES, signed compare.
//   - Out-of-bounds reads issue no address change and are tagged oob.
//   - rd_valid = rd_req delayed RD_LAT cycles. rd_data = oob ? 0 : sram_data_out[15:0].
//  ADC:
//   - adc_read = adc_ready & ~rd_req, so the FIFO is drained even when frozen or out of bounds.
//   - The pixel is written only if the state permits it and x < X_RES, y < Y_RES (unsigned).
//   - Every popped pixel that is not written increments adc_drop_cnt (saturates at 16'hFFFF).
//  SPI:
//   - One write per pending pixel; spi_busy blocks reissue while a write is in flight.
//   - Out-of-bounds coordinates are not written but are still acked.
//   - spi_ack pulses RD_LAT cycles after issue, then spi_busy clears.
//   - If state leaves FROZEN mid-flight, the ack is still delivered.
//  Write slot stolen by rd_req: the write is retried next free cycle; no data is lost, ADC is not popped.
// STRUCTURE
//  Package fg_sram_pkg: FSM state enum {LIVE, DRAIN, FROZEN, THAW}, RD_LAT, pixel/addr widths, ADC field offsets.
//  Sub-module freeze_fsm (state regs + frozen/adc_en/spi_en decode). The rest is flat in sram_access_scheduler.
// TESTING
//  1. rd_req (10,20) at t0 -> rd_valid=1 at t0+3, sram_addr=0x02814, rd_data=mem value. rd (-1,5) -> rd_data=0, rd_valid at t0+3.
//  2. adc_ready, adc pixel (5,5,0xABCD) in LIVE, rd_req=0 -> adc_read=1, sram_we=1, addr 0x01405. x=900 -> popped, no write, drop_cnt+1.
//  3. freeze_req=1 mid-frame -> ADC writes continue until frame_start, then frozen=1. Subsequent ADC pops are counted as drops.
//  4. FROZEN, spi_ready held 10 cycles at (1,1,0x1234) -> exactly one sram_we pulse, one spi_ack 3 cycles later.
//  5. Continuous rd_req for 50 cycles with adc_ready -> adc_read=0 throughout, no writes. First idle cycle writes the ADC pixel.
//  6. rst asserted 1 cycle after rd_req -> rd_valid never asserts, state=LIVE, all outputs 0 asynchronously.

Source files
------------

// File: rtl/fg_sram_pkg.sv
// Shared types and constants for the foreground SRAM access path.
package fg_sram_pkg;

  typedef enum logic [1:0] {
    StLive,
    StDrain,
    StFrozen,
    StThaw
  } frz_state_e;

  // Read latency is fixed by sram_interface.
  localparam int unsigned RdLat = 3;

  localparam int unsigned PixW  = 16;
  localparam int unsigned AddrW = 20;
  localparam int unsigned SramW = 17;

  localparam int unsigned AdcW      = 38;
  localparam int unsigned AdcFieldW = 11;
  localparam int unsigned AdcXLsb   = 27;
  localparam int unsigned AdcYLsb   = 16;

  function automatic logic [AddrW-1:0] pack_addr(input logic [9:0] x, input logic [9:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/freeze_fsm.sv
// Freeze-frame state machine; moves between live and frozen only on frame boundaries.
module freeze_fsm
  import fg_sram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic freeze_req_i,
  input  logic frame_start_i,
  output logic frozen_o,
  output logic adc_en_o,
  output logic spi_en_o
);

  frz_state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StLive;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLive: begin
        if (freeze_req_i) state_d = StDrain;
      end
      StDrain: begin
        if (frame_start_i)      state_d = StFrozen;
        else if (!freeze_req_i) state_d = StLive;
      end
      StFrozen: begin
        if (!freeze_req_i) state_d = StThaw;
      end
      StThaw: begin
        // A renewed freeze request beats the frame boundary.
        if (freeze_req_i)       state_d = StFrozen;
        else if (frame_start_i) state_d = StLive;
      end
      default: state_d = StLive;
    endcase
  end

  always_comb begin
    frozen_o = (state_q == StFrozen) || (state_q == StThaw);
    adc_en_o = (state_q == StLive) || (state_q == StDrain);
    spi_en_o = (state_q == StFrozen);
  end

endmodule

// File: rtl/sram_access_scheduler.sv
// Arbitrates the single foreground SRAM port between pipeline reads, ADC writes and SPI writes.
module sram_access_scheduler
  import fg_sram_pkg::*;
#(
  parameter int unsigned X_RES     = 800,
  parameter int unsigned Y_RES     = 600,
  parameter int unsigned PRECISION = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze_req,
  input  logic                        frame_start,
  output logic                        frozen,
  input  logic                        rd_req,
  input  logic signed [PRECISION:0]   rd_x,
  input  logic signed [PRECISION:0]   rd_y,
  output logic        [PixW-1:0]      rd_data,
  output logic                        rd_valid,
  input  logic        [AdcW-1:0]      adc_data,
  input  logic                        adc_ready,
  output logic                        adc_read,
  input  logic                        spi_ready,
  input  logic signed [PRECISION:0]   spi_x,
  input  logic signed [PRECISION:0]   spi_y,
  input  logic        [PixW-1:0]      spi_pixel,
  output logic                        spi_ack,
  output logic        [15:0]          adc_drop_cnt,
  output logic                        sram_we,
  output logic        [AddrW-1:0]     sram_addr,
  output logic        [SramW-1:0]     sram_data_in,
  input  logic        [SramW-1:0]     sram_data_out
);

  localparam logic [PRECISION-1:0] XLim    = PRECISION'(X_RES);
  localparam logic [PRECISION-1:0] YLim    = PRECISION'(Y_RES);
  localparam logic [AdcFieldW-1:0] AdcXLim = AdcFieldW'(X_RES);
  localparam logic [AdcFieldW-1:0] AdcYLim = AdcFieldW'(Y_RES);

  logic adc_en, spi_en;

  freeze_fsm u_freeze_fsm (
    .clk_i         (clk),
    .rst_i         (rst),
    .freeze_req_i  (freeze_req),
    .frame_start_i (frame_start),
    .frozen_o      (frozen),
    .adc_en_o      (adc_en),
    .spi_en_o      (spi_en)
  );

  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [SramW-1:0] din_q, din_d;
  logic [RdLat-1:0] rd_vld_q, rd_vld_d;
  logic [RdLat-1:0] rd_oob_q, rd_oob_d;
  logic [RdLat-1:0] spi_sr_q, spi_sr_d;
  logic             spi_busy_q, spi_busy_d;
  logic [15:0]      drop_q, drop_d;

  logic                 rd_inb, spi_inb, adc_inb;
  logic                 adc_wr, spi_issue, spi_wr;
  logic [AdcFieldW-1:0] adc_x, adc_y;
  logic [PixW-1:0]      adc_pix;
  logic                 unused_sram_msb;

  assign unused_sram_msb = sram_data_out[SramW-1];

  assign adc_x   = adc_data[AdcXLsb +: AdcFieldW];
  assign adc_y   = adc_data[AdcYLsb +: AdcFieldW];
  assign adc_pix = adc_data[PixW-1:0];

  // Signed bounds: a set sign bit is always out of range.
  assign rd_inb  = !rd_x[PRECISION] && (rd_x[PRECISION-1:0] < XLim) &&
                   !rd_y[PRECISION] && (rd_y[PRECISION-1:0] < YLim);
  assign spi_inb = !spi_x[PRECISION] && (spi_x[PRECISION-1:0] < XLim) &&
                   !spi_y[PRECISION] && (spi_y[PRECISION-1:0] < YLim);
  assign adc_inb = (adc_x < AdcXLim) && (adc_y < AdcYLim);

  // The FIFO is popped whenever the port is not taken by a read, even if the pixel is dropped.
  assign adc_read  = adc_ready && !rd_req;
  assign adc_wr    = adc_read && adc_en && adc_inb;
  assign spi_issue = spi_en && spi_ready && !spi_busy_q && !rd_req && !adc_wr;
  assign spi_wr    = spi_issue && spi_inb;

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    if (rd_req) begin
      if (rd_inb) addr_d = pack_addr(rd_x[9:0], rd_y[9:0]);
    end else if (adc_wr) begin
      we_d   = 1'b1;
      addr_d = pack_addr(adc_x[9:0], adc_y[9:0]);
      din_d  = {1'b0, adc_pix};
    end else if (spi_wr) begin
      we_d   = 1'b1;
      addr_d = pack_addr(spi_x[9:0], spi_y[9:0]);
      din_d  = {1'b0, spi_pixel};
    end

    rd_vld_d = {rd_vld_q[RdLat-2:0], rd_req};
    rd_oob_d = {rd_oob_q[RdLat-2:0], rd_req && !rd_inb};
    spi_sr_d = {spi_sr_q[RdLat-2:0], spi_issue};

    // Busy holds until the ack is out and the sender has withdrawn the pixel.
    spi_busy_d = spi_busy_q;
    if (spi_issue) begin
      spi_busy_d = 1'b1;
    end else if (spi_busy_q && (spi_sr_q == '0) && !spi_ready) begin
      spi_busy_d = 1'b0;
    end

    drop_d = drop_q;
    if (adc_read && !adc_wr && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_vld_q   <= '0;
      rd_oob_q   <= '0;
      spi_sr_q   <= '0;
      spi_busy_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_vld_q   <= rd_vld_d;
      rd_oob_q   <= rd_oob_d;
      spi_sr_q   <= spi_sr_d;
      spi_busy_q <= spi_busy_d;
      drop_q     <= drop_d;
    end
  end

  assign sram_we      = we_q;
  assign sram_addr    = addr_q;
  assign sram_data_in = din_q;
  assign adc_drop_cnt = drop_q;
  assign spi_ack      = spi_sr_q[RdLat-1];
  assign rd_valid     = rd_vld_q[RdLat-1];
  assign rd_data      = (rd_valid && !rd_oob_q[RdLat-1]) ? sram_data_out[PixW-1:0] : '0;

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Directed self-checking bench for sram_access_scheduler with a two-stage SRAM read model.
module tb_sram_access_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               freeze_req, frame_start, frozen;
  logic               rd_req, rd_valid;
  logic signed [11:0] rd_x, rd_y, spi_x, spi_y;
  logic [15:0]        rd_data, spi_pixel, adc_drop_cnt;
  logic [37:0]        adc_data;
  logic               adc_ready, adc_read, spi_ready, spi_ack, sram_we;
  logic [19:0]        sram_addr;
  logic [16:0]        sram_data_in, sram_data_out;

  logic [19:0]        mem_ad1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // SRAM stand-in: data appears RD_LAT cycles after the read request; bit 16 set to expose leaks.
  always_ff @(posedge clk) begin
    mem_ad1       <= sram_addr;
    sram_data_out <= {1'b1, mem_ad1[15:0] ^ 16'h5A5A};
  end

  sram_access_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .freeze_req    (freeze_req),
    .frame_start   (frame_start),
    .frozen        (frozen),
    .rd_req        (rd_req),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .adc_data      (adc_data),
    .adc_ready     (adc_ready),
    .adc_read      (adc_read),
    .spi_ready     (spi_ready),
    .spi_x         (spi_x),
    .spi_y         (spi_y),
    .spi_pixel     (spi_pixel),
    .spi_ack       (spi_ack),
    .adc_drop_cnt  (adc_drop_cnt),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int we_n, ack_n, we_i, ack_i, pops, wes, vld_n;
    logic [19:0] we_addr;
    logic [16:0] we_din;

    rst = 1'b1; freeze_req = 0; frame_start = 0; rd_req = 0; rd_x = 0; rd_y = 0;
    adc_data = '0; adc_ready = 0; spi_ready = 0; spi_x = 0; spi_y = 0; spi_pixel = 0;
    step(2);
    check_eq("rst_we", sram_we, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_frozen", frozen, 0);
    check_eq("rst_drop", adc_drop_cnt, 0);
    check_eq("rst_ack", spi_ack, 0);
    rst = 1'b0;
    step(1);

    // In-bounds read then out-of-bounds read.
    rd_req = 1; rd_x = 10; rd_y = 20;
    step(1);
    rd_req = 0;
    check_eq("rd_addr", sram_addr, 20'h02814);
    check_eq("rd_no_we", sram_we, 0);
    check_eq("rd_valid_t1", rd_valid, 0);
    step(1);
    check_eq("rd_valid_t2", rd_valid, 0);
    step(1);
    check_eq("rd_valid_t3", rd_valid, 1);
    check_eq("rd_data", rd_data, 16'h724E);
    rd_req = 1; rd_x = -1; rd_y = 5;
    step(1);
    rd_req = 0;
    check_eq("oob_addr_hold", sram_addr, 20'h02814);
    check_eq("rd_valid_pulse", rd_valid, 0);
    step(2);
    check_eq("oob_valid", rd_valid, 1);
    check_eq("oob_data", rd_data, 0);

    // ADC write in LIVE, then an out-of-range pixel that is popped and dropped.
    adc_ready = 1; adc_data = {11'd5, 11'd5, 16'hABCD};
    #1;
    check_eq("adc_read", adc_read, 1);
    step(1);
    adc_ready = 0;
    check_eq("adc_we", sram_we, 1);
    check_eq("adc_addr", sram_addr, 20'h01405);
    check_eq("adc_din", sram_data_in, 17'h0ABCD);
    check_eq("adc_drop0", adc_drop_cnt, 0);
    adc_ready = 1; adc_data = {11'd900, 11'd5, 16'h1111};
    #1;
    check_eq("adc_read_oob", adc_read, 1);
    step(1);
    adc_ready = 0;
    check_eq("adc_oob_we", sram_we, 0);
    check_eq("adc_drop1", adc_drop_cnt, 1);

    // Freeze request waits for the frame boundary; ADC still writes in DRAIN.
    freeze_req = 1;
    step(1);
    adc_ready = 1; adc_data = {11'd6, 11'd6, 16'h2222};
    step(1);
    adc_ready = 0;
    check_eq("drain_we", sram_we, 1);
    check_eq("drain_addr", sram_addr, 20'h01806);
    check_eq("drain_frozen", frozen, 0);
    frame_start = 1;
    step(1);
    frame_start = 0;
    check_eq("frozen", frozen, 1);
    adc_ready = 1; adc_data = {11'd7, 11'd7, 16'h4444};
    #1;
    check_eq("frz_adc_read", adc_read, 1);
    step(1);
    adc_ready = 0;
    check_eq("frz_adc_we", sram_we, 0);
    check_eq("frz_drop", adc_drop_cnt, 2);

    // SPI pixel held for 10 cycles: one write, one ack three cycles after issue.
    spi_ready = 1; spi_x = 1; spi_y = 1; spi_pixel = 16'h1234;
    we_n = 0; ack_n = 0; we_i = -1; ack_i = -1; we_addr = '0; we_din = '0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (sram_we) begin we_n++; we_i = i; we_addr = sram_addr; we_din = sram_data_in; end
      if (spi_ack) begin ack_n++; ack_i = i; end
    end
    spi_ready = 0;
    check_eq("spi_we_cnt", we_n, 1);
    check_eq("spi_we_cyc", we_i, 1);
    check_eq("spi_addr", we_addr, 20'h00401);
    check_eq("spi_din", we_din, 17'h01234);
    check_eq("spi_ack_cnt", ack_n, 1);
    check_eq("spi_ack_cyc", ack_i, 3);
    step(2);

    // Out-of-bounds SPI pixel is acked but never written.
    spi_ready = 1; spi_x = -2; spi_y = 3; spi_pixel = 16'h5555;
    we_n = 0; ack_n = 0; ack_i = -1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (sram_we) we_n++;
      if (spi_ack) begin ack_n++; ack_i = i; end
    end
    spi_ready = 0;
    check_eq("spi_oob_we", we_n, 0);
    check_eq("spi_oob_ack", ack_n, 1);
    check_eq("spi_oob_ack_cyc", ack_i, 3);
    step(2);

    // THAW: renewed request beats frame_start; then frame_start returns to LIVE.
    freeze_req = 0;
    step(1);
    check_eq("thaw_frozen", frozen, 1);
    freeze_req = 1; frame_start = 1;
    step(1);
    frame_start = 0;
    check_eq("thaw_refreeze", frozen, 1);
    freeze_req = 0;
    step(1);
    frame_start = 1;
    step(1);
    frame_start = 0;
    check_eq("thaw_live", frozen, 0);

    // Continuous reads starve the ADC; first idle cycle writes the pixel.
    rd_req = 1; rd_x = 10; rd_y = 20;
    adc_ready = 1; adc_data = {11'd8, 11'd9, 16'h3333};
    pops = 0; wes = 0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (adc_read) pops++;
      step(1);
      if (sram_we) wes++;
    end
    check_eq("starve_pops", pops, 0);
    check_eq("starve_we", wes, 0);
    rd_req = 0;
    #1;
    check_eq("idle_adc_read", adc_read, 1);
    step(1);
    adc_ready = 0;
    check_eq("idle_we", sram_we, 1);
    check_eq("idle_addr", sram_addr, 20'h02009);
    check_eq("idle_din", sram_data_in, 17'h03333);
    check_eq("idle_drop", adc_drop_cnt, 2);
    step(4);

    // Reset one cycle after a read: everything clears and the read never returns.
    freeze_req = 1;
    step(1);
    frame_start = 1;
    step(1);
    frame_start = 0;
    check_eq("pre_rst_frozen", frozen, 1);
    rd_req = 1; rd_x = 10; rd_y = 20;
    step(1);
    rd_req = 0; freeze_req = 0;
    rst = 1;
    #1;
    check_eq("arst_frozen", frozen, 0);
    check_eq("arst_addr", sram_addr, 0);
    check_eq("arst_din", sram_data_in, 0);
    check_eq("arst_drop", adc_drop_cnt, 0);
    check_eq("arst_valid", rd_valid, 0);
    check_eq("arst_rd_data", rd_data, 0);
    step(2);
    rst = 0;
    vld_n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (rd_valid) vld_n++;
    end
    check_eq("post_rst_valid", vld_n, 0);
    check_eq("post_rst_frozen", frozen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
